// File: rtl/io_deglitch_multi_pkg.sv
// Shared definitions for the multi-channel pad deglitcher: synchroniser depth limits,
// strobe bundle and the effective-threshold helper.
package io_deglitch_multi_pkg;

   localparam int unsigned SYNC_MIN = 2;
   localparam int unsigned SYNC_MAX = 4;

   typedef struct packed {
      logic rise;
      logic fall;
      logic glitch;
   } strobe_t;

   // A zero threshold would never qualify anything, so it behaves as one cycle.
   function automatic int unsigned eff_thresh(input int unsigned thresh);
      return (thresh == 0) ? 32'd1 : thresh;
   endfunction

endpackage

// File: rtl/io_deglitch_multi_if.sv
// Pad-side bundle of the deglitcher: raw inputs and controls in, filtered levels and strobes out.
interface io_deglitch_multi_if #(
   parameter int unsigned CH          = 2,
   parameter int unsigned COUNT_WIDTH = 3
);

   logic [CH-1:0]          in;
   logic [COUNT_WIDTH-1:0] thresh;
   logic                   bypass;
   logic [CH-1:0]          out;
   logic [CH-1:0]          rise;
   logic [CH-1:0]          fall;
   logic [CH-1:0]          glitch;

   modport master (
      output in, thresh, bypass,
      input  out, rise, fall, glitch
   );

   modport slave (
      input  in, thresh, bypass,
      output out, rise, fall, glitch
   );

endinterface

// File: rtl/io_deglitch_multi_chan.sv
// One filter channel: synchroniser chain, qualification counter, registered level and strobes.
module io_deglitch_chan
   import io_deglitch_multi_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic                   pin,
   input  logic [COUNT_WIDTH-1:0] thresh,
   input  logic                   bypass,
   output logic                   out,
   output logic                   rise,
   output logic                   fall,
   output logic                   glitch
);

   localparam int unsigned CW1 = COUNT_WIDTH + 1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   out_q, out_d;
   strobe_t                strb_q, strb_d;
   logic                   s;
   logic [COUNT_WIDTH:0]   cnt_inc;
   logic [COUNT_WIDTH:0]   eff;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
      s       = sync_q[SYNC_STAGES-1];
      // One extra bit so cnt+1 cannot wrap when thresh is at its maximum.
      cnt_inc = {1'b0, cnt_q} + CW1'(1);
      eff     = CW1'(eff_thresh(32'(thresh)));
      cnt_d   = cnt_q;
      out_d   = out_q;
      strb_d  = '0;
      if (bypass) begin
         out_d       = s;
         cnt_d       = '0;
         strb_d.rise = s & ~out_q;
         strb_d.fall = ~s & out_q;
      end else if (s == out_q) begin
         cnt_d         = '0;
         strb_d.glitch = (cnt_q != '0);
      end else if (cnt_inc >= eff) begin
         out_d       = s;
         cnt_d       = '0;
         strb_d.rise = s;
         strb_d.fall = ~s;
      end else begin
         cnt_d = cnt_inc[COUNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         cnt_q  <= '0;
         out_q  <= RST_VAL;
         strb_q <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         strb_q <= strb_d;
      end
   end

   assign out    = out_q;
   assign rise   = strb_q.rise;
   assign fall   = strb_q.fall;
   assign glitch = strb_q.glitch;

endmodule

// File: rtl/io_deglitch_multi.sv
// Multi-channel pad deglitcher: one independent filter channel per pin, shared threshold/bypass.
module io_deglitch_multi
   import io_deglitch_multi_pkg::*;
#(
   parameter int unsigned CH          = 2,
   parameter int unsigned COUNT_WIDTH = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b1
) (
   input logic               clk,
   input logic               rst_l,
   io_deglitch_multi_if.slave bus
);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("io_deglitch_multi: SYNC_STAGES must be within 2..4");
   end

   logic [CH-1:0]          out_v;
   logic [CH-1:0]          rise_v;
   logic [CH-1:0]          fall_v;
   logic [CH-1:0]          glitch_v;
   logic [COUNT_WIDTH-1:0] thresh_w;
   logic                   bypass_w;

   assign thresh_w = bus.thresh;
   assign bypass_w = bus.bypass;

   for (genvar g = 0; g < CH; g++) begin : g_chan
      io_deglitch_chan #(
         .COUNT_WIDTH (COUNT_WIDTH),
         .SYNC_STAGES (SYNC_STAGES),
         .RST_VAL     (RST_VAL)
      ) u_chan (
         .clk    (clk),
         .rst_l  (rst_l),
         .pin    (bus.in[g]),
         .thresh (thresh_w),
         .bypass (bypass_w),
         .out    (out_v[g]),
         .rise   (rise_v[g]),
         .fall   (fall_v[g]),
         .glitch (glitch_v[g])
      );
   end

   assign bus.out    = out_v;
   assign bus.rise   = rise_v;
   assign bus.fall   = fall_v;
   assign bus.glitch = glitch_v;

endmodule

// File: tb/tb_io_deglitch_multi.sv
// Directed bench for io_deglitch_multi (CH=2, COUNT_WIDTH=3, SYNC_STAGES=2, RST_VAL=1).
module tb_io_deglitch_multi;

   logic        clk = 1'b0;
   logic        rst_l;
   int unsigned tests = 0;
   int unsigned fails = 0;

   io_deglitch_multi_if #(.CH(2), .COUNT_WIDTH(3)) bus ();

   io_deglitch_multi #(
      .CH          (2),
      .COUNT_WIDTH (3),
      .SYNC_STAGES (2),
      .RST_VAL     (1'b1)
   ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      bus.in     = 2'b11;
      bus.bypass = 1'b0;
      bus.thresh = 3'd1;
      repeat (6) step();
   endtask

   // Observed vector layout: {out[1:0], rise[1:0], fall[1:0], glitch[1:0]}
   task automatic test_reset();
      logic [7:0] obs;
      rst_l      = 1'b0;
      bus.in     = 2'b00;
      bus.thresh = 3'd3;
      bus.bypass = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         step();
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== 8'b11_00_00_00) begin
            fails++;
            $display("FAIL reset_hold n=%0d obs=%b exp=%b", n, obs, 8'b11_00_00_00);
         end
      end
      rst_l  = 1'b1;
      bus.in = 2'b11;
      step();
      obs = {bus.out, bus.rise, bus.fall, bus.glitch};
      tests++;
      if (obs !== 8'b11_00_00_00) begin
         fails++;
         $display("FAIL reset_release obs=%b exp=%b", obs, 8'b11_00_00_00);
      end
      repeat (4) step();
      obs = {bus.out, bus.rise, bus.fall, bus.glitch};
      tests++;
      if (obs !== 8'b11_00_00_00) begin
         fails++;
         $display("FAIL reset_idle obs=%b exp=%b", obs, 8'b11_00_00_00);
      end
   endtask

   task automatic test_latency();
      logic [7:0] obs, exp;
      settle();
      bus.thresh = 3'd3;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         step();
         exp = {(n >= 5) ? 2'b10 : 2'b11, 2'b00, (n == 5) ? 2'b01 : 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL latency_t3 n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
   endtask

   task automatic test_glitch();
      logic [7:0] obs, exp;
      settle();
      bus.thresh = 3'd5;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (n == 3) bus.in[0] = 1'b1;
         exp = {2'b11, 2'b00, 2'b00, (n == 6) ? 2'b01 : 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL glitch_t5 n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
   endtask

   task automatic test_thresh();
      logic [7:0] obs, exp;
      // Zero threshold qualifies in a single cycle.
      settle();
      bus.thresh = 3'd0;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         step();
         exp = {(n >= 3) ? 2'b10 : 2'b11, 2'b00, (n == 3) ? 2'b01 : 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL thresh_zero n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
      // Maximum threshold: counter peaks at 6 and qualifies on the 7th.
      settle();
      bus.thresh = 3'd7;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         step();
         exp = {(n >= 9) ? 2'b10 : 2'b11, 2'b00, (n == 9) ? 2'b01 : 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL thresh_max n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
      // Lowered from 7 to 2 with cnt=3: qualifies on the next edge.
      settle();
      bus.thresh = 3'd7;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         step();
         if (n == 5) bus.thresh = 3'd2;
         exp = {(n >= 6) ? 2'b10 : 2'b11, 2'b00, (n == 6) ? 2'b01 : 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL thresh_lower n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
      // Raised from 3 to 5 with cnt=1: counting continues to the new value.
      settle();
      bus.thresh = 3'd3;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         step();
         if (n == 3) bus.thresh = 3'd5;
         exp = {(n >= 7) ? 2'b10 : 2'b11, 2'b00, (n == 7) ? 2'b01 : 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL thresh_raise n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
   endtask

   task automatic test_bypass();
      logic [7:0] obs, exp;
      settle();
      bus.thresh = 3'd7;
      bus.bypass = 1'b1;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         step();
         if (n == 1) bus.in[0] = 1'b1;
         exp = {(n == 3) ? 2'b10 : 2'b11, (n == 4) ? 2'b01 : 2'b00,
                (n == 3) ? 2'b01 : 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL bypass_pulse n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
      // Bypass asserted while a rejected pulse is counting: no glitch strobe.
      settle();
      bus.thresh = 3'd7;
      bus.in[0]  = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         step();
         if (n == 2) bus.in[0]  = 1'b1;
         if (n == 4) bus.bypass = 1'b1;
         if (n == 5) bus.bypass = 1'b0;
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== 8'b11_00_00_00) begin
            fails++;
            $display("FAIL bypass_midcount n=%0d obs=%b exp=%b", n, obs, 8'b11_00_00_00);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] obs, exp;
      settle();
      bus.thresh = 3'd3;
      for (int n = 1; n <= 12; n++) begin
         bus.in[0] = (n <= 8 && (n % 2) == 1) ? 1'b0 : 1'b1;
         step();
         exp = {2'b11, 2'b00, 2'b00,
                (n == 4 || n == 6 || n == 8 || n == 10) ? 2'b01 : 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL chatter n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
   endtask

   task automatic test_indep_reset();
      logic [7:0] obs, exp;
      settle();
      bus.thresh = 3'd3;
      bus.in     = 2'b01;
      for (int n = 1; n <= 13; n++) begin
         step();
         if (n == 2) bus.in = 2'b00;
         if (n == 5) rst_l  = 1'b0;
         if (n == 6) rst_l  = 1'b1;
         if (n == 5)       exp = {2'b01, 2'b00, 2'b10, 2'b00};
         else if (n == 11) exp = {2'b00, 2'b00, 2'b11, 2'b00};
         else if (n >= 12) exp = {2'b00, 2'b00, 2'b00, 2'b00};
         else              exp = {2'b11, 2'b00, 2'b00, 2'b00};
         obs = {bus.out, bus.rise, bus.fall, bus.glitch};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL indep_reset n=%0d obs=%b exp=%b", n, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_thresh();
      test_bypass();
      test_back_to_back();
      test_indep_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
